// File: rtl/round_ctrl_param.sv
// round_ctrl_param
//   Round controller for the block-cipher datapath. After an accepted start it
//   spends one cycle loading the datapath and key schedule, then runs NROUNDS
//   rounds while presenting the round index on rc. Then it pulses done and
//   returns to idle. rc counts up (dec=0) or down (dec=1). stall freezes the
//   current round. abort drops the block without a done pulse.
//
// Parameters
//   RC_W     width of the round counter
//   NROUNDS  rounds per block, 1 .. 2**RC_W
//
// Ports
//   CK     in   clock, all state changes on posedge
//   RN     in   synchronous active-low reset
//   start  in   request a new block (taken only while ready)
//   dec    in   direction, sampled with an accepted start (1 = count down)
//   stall  in   hold the current round (RUN only)
//   abort  in   cancel the block in progress
//   ready  out  idle, start will be accepted
//   busy   out  block in progress (LOAD, RUN or DONE)
//   act    out  round datapath enable, high exactly in RUN
//   rc     out  current round index
//   first  out  RUN and rc is the first round index
//   last   out  RUN and rc is the final round index
//   done   out  one-cycle pulse after the final round
module round_ctrl_param #(
  parameter int RC_W    = 5,
  parameter int NROUNDS = 32
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            start,
  input  logic            dec,
  input  logic            stall,
  input  logic            abort,
  output logic            ready,
  output logic            busy,
  output logic            act,
  output logic [RC_W-1:0] rc,
  output logic            first,
  output logic            last,
  output logic            done
);

  // An out-of-range round count cannot be represented in rc, so elaboration
  // refuses it.
  if (NROUNDS < 1 || NROUNDS > (1 << RC_W)) begin : g_bad_nrounds
    $error("round_ctrl_param: NROUNDS=%0d outside 1..2**RC_W", NROUNDS);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [RC_W-1:0] RC_MAX = RC_W'(NROUNDS - 1);

  state_t          state_reg, state_next;
  logic [RC_W-1:0] rc_reg, rc_next;
  logic            mode_reg, mode_next;

  // Start and end indices swap with the latched direction.
  logic [RC_W-1:0] start_idx;
  logic [RC_W-1:0] end_idx;
  logic            at_end;

  assign start_idx = mode_reg ? RC_MAX : '0;
  assign end_idx   = mode_reg ? '0 : RC_MAX;
  assign at_end    = (rc_reg == end_idx);

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_reg <= IDLE;
      rc_reg    <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rc_reg    <= rc_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rc_next    = rc_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        // abort has no meaning here, so start wins when both are present.
        if (start) begin
          state_next = LOAD;
          mode_next  = dec;
          rc_next    = dec ? RC_MAX : '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
          rc_next    = '0;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // abort beats both stall and the final-round exit.
        if (abort) begin
          state_next = IDLE;
          rc_next    = '0;
        end else if (!stall) begin
          if (at_end) begin
            state_next = DONE;      // rc keeps the final index
          end else if (mode_reg) begin
            rc_next = rc_reg - RC_W'(1);
          end else begin
            rc_next = rc_reg + RC_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (abort) begin
          rc_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        rc_next    = '0;
      end
    endcase
  end

  // Every output decodes registered state only.
  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg != IDLE);
  assign act   = (state_reg == RUN);
  assign rc    = rc_reg;
  assign first = (state_reg == RUN) && (rc_reg == start_idx);
  assign last  = (state_reg == RUN) && at_end;
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_round_ctrl_param.sv
// tb_round_ctrl_param
//   Three controllers share one stimulus stream: (RC_W=5, NROUNDS=32),
//   (RC_W=5, NROUNDS=1) and (RC_W=4, NROUNDS=16). A block-level model counts
//   completed rounds per instance and derives the expected outputs every cycle.
//   Directed literal checks pin rc sequences, latencies and strobes.
module tb_round_ctrl_param;

  logic CK;
  logic RN, start, dec, stall, abort;

  logic       ready0, busy0, act0, first0, last0, done0;
  logic [4:0] rc0;
  logic       ready1, busy1, act1, first1, last1, done1;
  logic [4:0] rc1;
  logic       ready2, busy2, act2, first2, last2, done2;
  logic [3:0] rc2;

  round_ctrl_param #(.RC_W(5), .NROUNDS(32)) u0 (
    .CK(CK), .RN(RN), .start(start), .dec(dec), .stall(stall), .abort(abort),
    .ready(ready0), .busy(busy0), .act(act0), .rc(rc0),
    .first(first0), .last(last0), .done(done0));

  round_ctrl_param #(.RC_W(5), .NROUNDS(1)) u1 (
    .CK(CK), .RN(RN), .start(start), .dec(dec), .stall(stall), .abort(abort),
    .ready(ready1), .busy(busy1), .act(act1), .rc(rc1),
    .first(first1), .last(last1), .done(done1));

  round_ctrl_param #(.RC_W(4), .NROUNDS(16)) u2 (
    .CK(CK), .RN(RN), .start(start), .dec(dec), .stall(stall), .abort(abort),
    .ready(ready2), .busy(busy2), .act(act2), .rc(rc2),
    .first(first2), .last(last2), .done(done2));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int nr(input int i);
    case (i)
      0:       return 32;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Round position k -> round index for the given direction.
  function automatic int pos(input int n, input bit d, input int k);
    return d ? (n - 1 - k) : k;
  endfunction

  bit m_active [3];   // block accepted and not yet finished
  bit m_loaded [3];   // load cycle already spent
  bit m_dec    [3];
  int m_k      [3];   // rounds completed; == N means the done cycle
  int m_idle_rc[3];   // rc value shown while idle

  always @(posedge CK) begin
    for (int i = 0; i < 3; i++) begin
      if (!RN) begin
        m_active[i]  <= 1'b0;
        m_loaded[i]  <= 1'b0;
        m_dec[i]     <= 1'b0;
        m_k[i]       <= 0;
        m_idle_rc[i] <= 0;
      end else if (!m_active[i]) begin
        if (start) begin
          m_active[i] <= 1'b1;
          m_loaded[i] <= 1'b0;
          m_k[i]      <= 0;
          m_dec[i]    <= dec;
        end
      end else if (abort) begin
        m_active[i]  <= 1'b0;
        m_idle_rc[i] <= 0;
      end else if (!m_loaded[i]) begin
        m_loaded[i] <= 1'b1;
      end else if (m_k[i] < nr(i)) begin
        if (!stall) m_k[i] <= m_k[i] + 1;
      end else begin
        m_active[i]  <= 1'b0;
        m_idle_rc[i] <= pos(nr(i), m_dec[i], nr(i) - 1);
      end
    end
  end

  int o_ready[3], o_busy[3], o_act[3], o_rc[3], o_first[3], o_last[3], o_done[3];
  always_comb begin
    o_ready[0] = int'(ready0); o_busy[0] = int'(busy0); o_act[0] = int'(act0);
    o_rc[0] = int'(rc0); o_first[0] = int'(first0); o_last[0] = int'(last0);
    o_done[0] = int'(done0);
    o_ready[1] = int'(ready1); o_busy[1] = int'(busy1); o_act[1] = int'(act1);
    o_rc[1] = int'(rc1); o_first[1] = int'(first1); o_last[1] = int'(last1);
    o_done[1] = int'(done1);
    o_ready[2] = int'(ready2); o_busy[2] = int'(busy2); o_act[2] = int'(act2);
    o_rc[2] = int'(rc2); o_first[2] = int'(first2); o_last[2] = int'(last2);
    o_done[2] = int'(done2);
  end

  always @(negedge CK) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int n, kk, e_act, e_rc;
        n     = nr(i);
        e_act = (m_active[i] && m_loaded[i] && m_k[i] < n) ? 1 : 0;
        kk    = (m_k[i] < n) ? m_k[i] : n - 1;
        e_rc  = m_active[i] ? pos(n, m_dec[i], kk) : m_idle_rc[i];
        chk($sformatf("u%0d.ready", i), o_ready[i], m_active[i] ? 0 : 1);
        chk($sformatf("u%0d.busy", i),  o_busy[i],  m_active[i] ? 1 : 0);
        chk($sformatf("u%0d.act", i),   o_act[i],   e_act);
        chk($sformatf("u%0d.rc", i),    o_rc[i],    e_rc);
        chk($sformatf("u%0d.first", i), o_first[i], (e_act == 1 && m_k[i] == 0) ? 1 : 0);
        chk($sformatf("u%0d.last", i),  o_last[i],  (e_act == 1 && m_k[i] == n - 1) ? 1 : 0);
        chk($sformatf("u%0d.done", i),  o_done[i],
            (m_active[i] && m_loaded[i] && m_k[i] == n) ? 1 : 0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic pulse_start(input bit d);
    dec   = d;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Edges from acceptance until done0 is seen, with optional stalls.
  // mode 0: none; 1: 3 cycles at rc0==10; 2: 4 cycles on the last round.
  task automatic run_count(input int mode, output int edges);
    int nst = 0;
    edges = 0;
    while (!done0 && edges < 200) begin
      if (mode == 1 && act0 && rc0 == 5'd10 && nst < 3) begin
        stall = 1'b1; nst++;
      end else if (mode == 2 && act0 && last0 && nst < 4) begin
        stall = 1'b1; nst++;
      end else begin
        stall = 1'b0;
      end
      step(1);
      edges++;
      if (nst > 0 && nst <= 3 && mode == 1 && stall) begin
        chk("stall_rc_hold", int'(rc0), 10);
        chk("stall_act", int'(act0), 1);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    int lat;
    RN = 1'b0; start = 1'b0; dec = 1'b0; stall = 1'b0; abort = 1'b0;
    step(2);
    RN = 1'b1;
    chk_en = 1'b1;
    // 1 reset state
    chk("rst_ready", int'(ready0), 1);
    chk("rst_busy",  int'(busy0), 0);
    chk("rst_act",   int'(act0), 0);
    chk("rst_rc",    int'(rc0), 0);
    chk("rst_done",  int'(done0), 0);
    step(1);

    // 2 encrypt, plus NROUNDS=1 and RC_W=4 instances on the same block
    pulse_start(1'b0);
    chk("enc_load_act",  int'(act0), 0);
    chk("enc_load_busy", int'(busy0), 1);
    chk("enc_load_rdy",  int'(ready0), 0);
    for (int i = 0; i < 32; i++) begin
      step(1);
      chk("enc_act",   int'(act0), 1);
      chk("enc_rc",    int'(rc0), i);
      chk("enc_first", int'(first0), (i == 0) ? 1 : 0);
      chk("enc_last",  int'(last0), (i == 31) ? 1 : 0);
      chk("enc_done",  int'(done0), 0);
      if (i == 0) begin
        chk("n1_first", int'(first1), 1);
        chk("n1_last",  int'(last1), 1);
        chk("n1_act",   int'(act1), 1);
      end
      if (i == 1) chk("n1_done_t2", int'(done1), 1);
      if (i < 16) chk("w4_rc", int'(rc2), i);
      if (i == 15) chk("w4_last", int'(last2), 1);
      if (i == 16) begin
        chk("w4_done", int'(done2), 1);
        chk("w4_rc_hold", int'(rc2), 15);
      end
    end
    step(1);
    chk("enc_done_pulse", int'(done0), 1);
    chk("enc_done_act",   int'(act0), 0);
    chk("enc_done_rc",    int'(rc0), 31);
    start = 1'b1;              // start in DONE cycle is ignored
    step(1);
    start = 1'b0;
    chk("enc_ready_back", int'(ready0), 1);
    chk("done_start_ign", int'(busy0), 0);
    chk("enc_done_once",  int'(done0), 0);
    step(2);

    // 3 decrypt, dec toggled and start pulsed mid-block
    pulse_start(1'b1);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) dec = 1'b0;
      start = (i == 10);
      step(1);
      chk("dec_rc",    int'(rc0), 31 - i);
      chk("dec_first", int'(first0), (i == 0) ? 1 : 0);
      chk("dec_last",  int'(last0), (i == 31) ? 1 : 0);
    end
    start = 1'b0;
    step(1);
    chk("dec_done", int'(done0), 1);
    chk("dec_done_rc", int'(rc0), 0);
    step(1);
    chk("dec_idle", int'(ready0), 1);
    step(2);

    // latency baselines
    pulse_start(1'b0);
    run_count(0, lat);
    chk("lat_nostall", lat, 33);
    step(3);

    // 4 stall
    pulse_start(1'b0);
    run_count(1, lat);
    chk("lat_stall3", lat, 36);
    step(3);
    pulse_start(1'b0);
    run_count(2, lat);
    chk("lat_stall_last", lat, 37);
    chk("stall_last_rc", int'(rc0), 31);
    step(3);

    // 5 abort at rc=5 with stall
    pulse_start(1'b0);
    lat = 0;
    while (!(act0 && rc0 == 5'd5) && lat < 50) begin
      step(1);
      lat++;
    end
    chk("abort_reach_rc5", (lat < 50) ? 1 : 0, 1);
    stall = 1'b1; abort = 1'b1;
    step(1);
    stall = 1'b0; abort = 1'b0;
    chk("abort_ready", int'(ready0), 1);
    chk("abort_rc",    int'(rc0), 0);
    chk("abort_busy",  int'(busy0), 0);
    chk("abort_w4_rc", int'(rc2), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("abort_no_done", int'(done0), 0);
    end
    abort = 1'b1;              // abort in IDLE has no effect
    step(1);
    abort = 1'b0;
    chk("abort_idle", int'(ready0), 1);
    // start + abort together in IDLE -> accepted
    start = 1'b1; abort = 1'b1; dec = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", int'(busy0), 1);
    chk("startabort_rc",   int'(rc0), 31);
    run_count(0, lat);
    chk("startabort_lat", lat, 33);
    step(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
